// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings, state type and bus command payload for the MEM-stage data-memory controller.
package dmem_access_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned TYPE_W = 3;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 8;

    localparam logic [TYPE_W-1:0] LD_LB  = 3'b000;
    localparam logic [TYPE_W-1:0] LD_LH  = 3'b001;
    localparam logic [TYPE_W-1:0] LD_LW  = 3'b010;
    localparam logic [TYPE_W-1:0] LD_LBU = 3'b100;
    localparam logic [TYPE_W-1:0] LD_LHU = 3'b101;

    localparam logic [TYPE_W-1:0] ST_SB  = 3'b000;
    localparam logic [TYPE_W-1:0] ST_SH  = 3'b001;
    localparam logic [TYPE_W-1:0] ST_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } bus_cmd_t;

    function automatic logic type_legal(input logic write, input logic [TYPE_W-1:0] t);
        if (write) begin
            return (t == ST_SB) || (t == ST_SH) || (t == ST_SW);
        end
        return (t == LD_LB) || (t == LD_LBU) || (t == LD_LH) || (t == LD_LHU) || (t == LD_LW);
    endfunction

    // Width is encoded in t[1:0] identically for loads and stores.
    function automatic logic addr_aligned(input logic [TYPE_W-1:0] t, input logic [1:0] lane);
        case (t[1:0])
            2'b01:   return !lane[0];
            2'b10:   return lane == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_load_extract.sv
// Selects the addressed byte/halfword/word from a bus read word and extends it to 32 bits.
module dmem_access_ctrl_load_extract
    import dmem_access_ctrl_pkg::*;
(
    input  logic [XLEN-1:0]   bus_rdata,
    input  logic [TYPE_W-1:0] ld_type,
    input  logic [1:0]        lane,
    output logic [XLEN-1:0]   ext_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = bus_rdata[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ext_data = '0;
        case (ld_type)
            LD_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  ext_data = {24'h000000, byte_sel};
            LD_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  ext_data = {16'h0000, half_sel};
            LD_LW:   ext_data = bus_rdata;
            default: ext_data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store controller: one access per request over a req/ack bus with bounded wait,
// alignment/type checking and a single-cycle registered response.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [TYPE_W-1:0]   req_type,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                stall,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_err,
    output logic                bus_req,
    output logic                bus_we,
    output logic [XLEN-1:0]     bus_addr,
    output logic [BE_W-1:0]     bus_be,
    output logic [XLEN-1:0]     bus_wdata,
    input  logic                bus_ack,
    input  logic [XLEN-1:0]     bus_rdata
);

    state_t              state_q, state_d;
    bus_cmd_t            cmd_q, cmd_d;
    logic                bus_req_q, bus_req_d;
    logic [TYPE_W-1:0]   type_q, type_d;
    logic [1:0]          lane_q, lane_d;
    logic [CNT_W-1:0]    wait_q, wait_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [XLEN-1:0]     rsp_rdata_q, rsp_rdata_d;

    logic [1:0]          req_lane;
    logic                req_ok;
    logic [BE_W-1:0]     st_be;
    logic [XLEN-1:0]     st_wdata;
    logic [XLEN-1:0]     load_data;

    dmem_access_ctrl_load_extract u_load_extract (
        .bus_rdata (bus_rdata),
        .ld_type   (type_q),
        .lane      (lane_q),
        .ext_data  (load_data)
    );

    // Store byte enables and lane-replicated write data
    always_comb begin
        req_lane = req_addr[1:0];
        req_ok   = type_legal(req_write, req_type) && addr_aligned(req_type, req_lane);
        st_be    = 4'b1111;
        st_wdata = req_wdata;
        case (req_type)
            ST_SB: begin
                st_be    = 4'b0001 << req_lane;
                st_wdata = {4{req_wdata[7:0]}};
            end
            ST_SH: begin
                st_be    = 4'b0011 << req_lane;
                st_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = req_wdata;
            end
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        bus_req_d   = bus_req_q;
        type_d      = type_q;
        lane_d      = lane_q;
        wait_d      = wait_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_ok) begin
                        state_d     = S_BUSY;
                        bus_req_d   = 1'b1;
                        cmd_d.we    = req_write;
                        cmd_d.addr  = {req_addr[31:2], 2'b00};
                        cmd_d.be    = req_write ? st_be : 4'b1111;
                        cmd_d.wdata = req_write ? st_wdata : '0;
                        type_d      = req_type;
                        lane_d      = req_lane;
                        wait_d      = '0;
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                // An ack in the expiry cycle takes priority over the timeout
                if (bus_ack) begin
                    state_d     = S_RESP;
                    bus_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = cmd_q.we ? '0 : load_data;
                end else if (wait_q == CNT_W'(MAX_WAIT - 1)) begin
                    state_d     = S_RESP;
                    bus_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            bus_req_q   <= 1'b0;
            type_q      <= '0;
            lane_q      <= '0;
            wait_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            bus_req_q   <= bus_req_d;
            type_q      <= type_d;
            lane_q      <= lane_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Stall must react to req_valid in the same cycle, so it is decoded from state
    assign stall     = ((state_q == S_IDLE) && req_valid) || (state_q == S_BUSY);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = cmd_q.we;
    assign bus_addr  = cmd_q.addr;
    assign bus_be    = cmd_q.be;
    assign bus_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed, table-driven bench for dmem_access_ctrl with hand-computed expectations.
module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

    localparam int unsigned MW = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_write;
    logic [2:0]  req_type;
    logic [31:0] req_addr, req_wdata;
    logic        stall, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    dmem_access_ctrl #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_write(req_write), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        write;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_k;
        int          exp_cyc;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_bus;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [2:0] t, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd, input int k,
                                input int cyc, input logic [31:0] erd, input logic err,
                                input int nbus, input logic [31:0] ea, input logic [3:0] ebe,
                                input logic [31:0] ewd);
        vec_t v;
        v.write = w; v.typ = t; v.addr = a; v.wdata = wd; v.rdata = rd; v.ack_k = k;
        v.exp_cyc = cyc; v.exp_rdata = erd; v.exp_err = err; v.exp_bus = nbus;
        v.exp_addr = ea; v.exp_be = ebe; v.exp_wdata = ewd;
        return v;
    endfunction

    int          obs_cyc, obs_bus, obs_unstable, obs_stall_bad;
    logic [31:0] obs_rdata, obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_err, obs_we;

    // Presents one request at cycle 0 and observes until the response (bounded)
    task automatic run_txn(input logic w, input logic [2:0] t, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int k);
        obs_cyc = -1; obs_bus = 0; obs_unstable = 0; obs_stall_bad = 0;
        obs_rdata = '0; obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_err = 1'b0; obs_we = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_write = w; req_type = t; req_addr = a; req_wdata = wd;
        bus_rdata = rd; bus_ack = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus_req) begin
                if (obs_bus == 0) begin
                    obs_addr = bus_addr; obs_be = bus_be; obs_wdata = bus_wdata; obs_we = bus_we;
                end else if (bus_addr !== obs_addr || bus_be !== obs_be ||
                             bus_wdata !== obs_wdata || bus_we !== obs_we) begin
                    obs_unstable++;
                end
                obs_bus++;
            end
            if (rsp_valid) begin
                obs_cyc = c; obs_rdata = rsp_rdata; obs_err = rsp_err;
                if (stall) obs_stall_bad++;
                req_valid = 1'b0; bus_ack = 1'b0;
                break;
            end
            if (!stall) obs_stall_bad++;
            bus_ack = (c == k);
        end
        req_valid = 1'b0;
        bus_ack   = 1'b0;
    endtask

    vec_t vecs[$];
    int   bad;

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_type = '0;
        req_addr = '0; req_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;

        // Reset state
        #2;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        vecs.push_back(mk(0, LD_LB,  32'h103, 32'h0,        32'h80FF1234,  1, 2, 32'hFFFFFF80, 0, 1, 32'h100, 4'hF,    32'h0));
        vecs.push_back(mk(0, LD_LHU, 32'h102, 32'h0,        32'h80015555,  4, 5, 32'h00008001, 0, 4, 32'h100, 4'hF,    32'h0));
        vecs.push_back(mk(1, ST_SB,  32'h201, 32'h123456AB, 32'hDEADDEAD,  2, 3, 32'h0,        0, 2, 32'h200, 4'b0010, 32'hABABABAB));
        vecs.push_back(mk(0, LD_LW,  32'h102, 32'h0,        32'h0,        -1, 1, 32'h0,        1, 0, 32'h0,   4'h0,    32'h0));
        vecs.push_back(mk(0, LD_LW,  32'h300, 32'h0,        32'h55555555, -1, 5, 32'h0,        1, 4, 32'h300, 4'hF,    32'h0));
        vecs.push_back(mk(0, LD_LH,  32'h006, 32'h0,        32'h87654321,  1, 2, 32'hFFFF8765, 0, 1, 32'h004, 4'hF,    32'h0));
        vecs.push_back(mk(0, LD_LBU, 32'h001, 32'h0,        32'h0000F200,  1, 2, 32'h000000F2, 0, 1, 32'h000, 4'hF,    32'h0));
        vecs.push_back(mk(1, ST_SH,  32'h00A, 32'hDEADBEEF, 32'h0,         1, 2, 32'h0,        0, 1, 32'h008, 4'b1100, 32'hBEEFBEEF));
        vecs.push_back(mk(1, ST_SW,  32'h010, 32'hCAFEF00D, 32'h0,         3, 4, 32'h0,        0, 3, 32'h010, 4'hF,    32'hCAFEF00D));
        vecs.push_back(mk(0, 3'b011, 32'h000, 32'h0,        32'h0,        -1, 1, 32'h0,        1, 0, 32'h0,   4'h0,    32'h0));
        vecs.push_back(mk(1, 3'b100, 32'h000, 32'h1,        32'h0,        -1, 1, 32'h0,        1, 0, 32'h0,   4'h0,    32'h0));
        vecs.push_back(mk(1, ST_SH,  32'h003, 32'hFFFF,     32'h0,        -1, 1, 32'h0,        1, 0, 32'h0,   4'h0,    32'h0));
        vecs.push_back(mk(0, LD_LB,  32'h000, 32'h0,        32'h0000007F,  1, 2, 32'h0000007F, 0, 1, 32'h000, 4'hF,    32'h0));
        vecs.push_back(mk(0, LD_LW,  32'h020, 32'h0,        32'h13579BDF,  1, 2, 32'h13579BDF, 0, 1, 32'h020, 4'hF,    32'h0));
        vecs.push_back(mk(0, LD_LH,  32'h100, 32'h0,        32'h1234FFFE,  1, 2, 32'hFFFFFFFE, 0, 1, 32'h100, 4'hF,    32'h0));
        vecs.push_back(mk(0, LD_LB,  32'h102, 32'h0,        32'h00AB0000,  2, 3, 32'hFFFFFFAB, 0, 2, 32'h100, 4'hF,    32'h0));

        foreach (vecs[i]) begin
            run_txn(vecs[i].write, vecs[i].typ, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].ack_k);
            check($sformatf("v%0d_rsp_cycle", i), 32'(obs_cyc), 32'(vecs[i].exp_cyc));
            check($sformatf("v%0d_rsp_rdata", i), obs_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_rsp_err", i), 32'(obs_err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_bus_cycles", i), 32'(obs_bus), 32'(vecs[i].exp_bus));
            check($sformatf("v%0d_bus_addr", i), obs_addr, vecs[i].exp_addr);
            check($sformatf("v%0d_bus_be", i), 32'(obs_be), 32'(vecs[i].exp_be));
            check($sformatf("v%0d_bus_we", i), 32'(obs_we),
                  32'((vecs[i].exp_bus > 0) ? vecs[i].write : 1'b0));
            if (vecs[i].write)
                check($sformatf("v%0d_bus_wdata", i), obs_wdata, vecs[i].exp_wdata);
            check($sformatf("v%0d_stall_bad", i), 32'(obs_stall_bad), 32'd0);
            check($sformatf("v%0d_bus_unstable", i), 32'(obs_unstable), 32'd0);
        end

        // Timeout followed by a late ack in the next (idle) cycle
        run_txn(1'b0, LD_LW, 32'h300, 32'h0, 32'hA5A5A5A5, -1);
        check("late_timeout_cycle", 32'(obs_cyc), 32'd5);
        check("late_timeout_err", 32'(obs_err), 32'd1);
        @(posedge clk);
        #1 bus_ack = 1'b1;
        @(negedge clk);
        check("late_ack_bus_req", 32'(bus_req), 32'd0);
        check("late_ack_rsp_valid_c6", 32'(rsp_valid), 32'd0);
        check("late_ack_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 bus_ack = 1'b0;
        @(negedge clk);
        check("late_ack_rsp_valid_c7", 32'(rsp_valid), 32'd0);

        // Reset pulse during BUSY abandons the access
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_write = 1'b0; req_type = LD_LW; req_addr = 32'h40; bus_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy_before_rst_bus_req", 32'(bus_req), 32'd1);
        #2;
        rstn = 1'b0; req_valid = 1'b0;
        #1;
        check("rst_async_bus_req", 32'(bus_req), 32'd0);
        check("rst_async_stall", 32'(stall), 32'd0);
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rsp_valid || bus_req) bad++;
        end
        rstn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (rsp_valid || bus_req) bad++;
        end
        check("rst_no_response", 32'(bad), 32'd0);
        run_txn(1'b0, LD_LW, 32'h0, 32'h0, 32'h11223344, 1);
        check("post_rst_rsp_cycle", 32'(obs_cyc), 32'd2);
        check("post_rst_rsp_rdata", obs_rdata, 32'h11223344);
        check("post_rst_rsp_err", 32'(obs_err), 32'd0);
        check("post_rst_bus_addr", obs_addr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
